// File: rtl/dcr_pkg.sv
// dcr_pkg: shared widths and types for the DCR access arbiter
// and the register file it fronts.
package dcr_pkg;

   localparam int DCR_ADDR_W = 4;
   localparam int DCR_DATA_W = 8;
   localparam int DCR_DEPTH  = 16;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } dcr_arb_state_t;

   typedef struct packed {
      logic                  write;
      logic [DCR_ADDR_W-1:0] addr;
      logic [DCR_DATA_W-1:0] wdata;
   } dcr_req_t;

endpackage

// File: rtl/dcr_arbiter_if.sv
// dcr_arbiter_if: per-requester transaction request/response bundle.
// master = requesters, slave = arbiter.
interface dcr_arbiter_if
   import dcr_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = DCR_ADDR_W,
   parameter int DATA_W  = DCR_DATA_W
);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_write;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_wdata;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]         rsp_rdata;
   logic [NUM_REQ-1:0]        rsp_ready;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata
   );

endinterface

// File: rtl/dcr_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector; search starts at ptr
// and wraps, first set request wins.
module rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_id,
   output logic               any
);

   int idx;

   always_comb begin
      grant    = '0;
      grant_id = '0;
      any      = 1'b0;
      idx      = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (!any && req[idx]) begin
            any        = 1'b1;
            grant[idx] = 1'b1;
            grant_id   = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/dcr_arbiter.sv
// dcr_arbiter: serialises single-beat requester transactions onto
// the shared DCR file port, round-robin among requesters.
module dcr_arbiter
   import dcr_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = DCR_ADDR_W,
   parameter int DATA_W  = DCR_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   dcr_arbiter_if.slave      bus,
   output logic              dcr_write_enable,
   output logic [DATA_W-1:0] dcr_data_in,
   output logic [ADDR_W-1:0] dcr_control_select,
   input  logic [DATA_W-1:0] dcr_control_status,
   output logic              busy
);

   localparam int ID_W = $clog2(NUM_REQ);

   dcr_arb_state_t     state;
   dcr_req_t           req_q;
   logic [ID_W-1:0]    id_q;
   logic [ID_W-1:0]    rr_ptr;
   logic [DATA_W-1:0]  rdata_q;
   logic [NUM_REQ-1:0] win;
   logic [ID_W-1:0]    win_id;
   logic               win_any;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_picker (
      .req      (bus.req_valid),
      .ptr      (rr_ptr),
      .grant    (win),
      .grant_id (win_id),
      .any      (win_any)
   );

   // Gated by reset so no accept strobe leaks while reset is held.
   always_comb begin
      bus.req_ready = '0;
      if (reset && state == IDLE)
         bus.req_ready = win;
   end

   always_comb begin
      bus.rsp_valid = '0;
      if (state == RESP)
         bus.rsp_valid[id_q] = 1'b1;
   end

   assign bus.rsp_rdata        = rdata_q;
   assign dcr_write_enable     = (state == ACCESS) && req_q.write;
   assign dcr_data_in          = req_q.wdata;
   assign dcr_control_select   = req_q.addr;
   assign busy                 = (state != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         req_q   <= '0;
         id_q    <= '0;
         rr_ptr  <= '0;
         rdata_q <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (win_any) begin
                  id_q        <= win_id;
                  req_q.write <= bus.req_write[win_id];
                  req_q.addr  <= bus.req_addr[int'(win_id)*ADDR_W +: ADDR_W];
                  req_q.wdata <= bus.req_wdata[int'(win_id)*DATA_W +: DATA_W];
                  state       <= ACCESS;
               end
            end
            ACCESS: begin
               rdata_q <= req_q.write ? req_q.wdata : dcr_control_status;
               state   <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready[id_q]) begin
                  rr_ptr <= (id_q == ID_W'(NUM_REQ-1)) ? '0 : id_q + 1'b1;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
